// File: rtl/mem_wb_stage_reg_if.sv
// MEM->WB stage bundle: valid/ready handshake plus write-back payload.
// Latency: none, wiring only.
// Backpressure: ready flows from the consumer back to the producer (master drives valid/payload).
interface mem_wb_stage_reg_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               valid;
  logic               ready;
  logic [XLEN-1:0]    ALUResult;
  logic [XLEN-1:0]    ReadData;
  logic [XLEN-1:0]    PCPlus4;
  logic [RADDR_W-1:0] Rd;
  logic               RegWrite;
  logic [1:0]         ResultSrc;

  modport master (
    output valid, ALUResult, ReadData, PCPlus4, Rd, RegWrite, ResultSrc,
    input  ready
  );

  modport slave (
    input  valid, ALUResult, ReadData, PCPlus4, Rd, RegWrite, ResultSrc,
    output ready
  );
endinterface

// File: rtl/mem_wb_stage_reg.sv
// Elastic MEM->WB pipeline register with a 2-entry skid buffer; optional perf counters via MEMWB_PERF_EN.
// Latency: 1 cycle from accept to out_valid; 1 entry/cycle throughput when WB keeps ready high.
// Backpressure: in_ready = !skid_valid (registered state only), so WB stalls never form a comb path to MEM.
module mem_wb_stage_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  mem_wb_stage_reg_if.slave    mem_in,
  mem_wb_stage_reg_if.master   wb_out,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    read_data;
    logic [XLEN-1:0]    pc_plus4;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
    logic [1:0]         result_src;
  } payload_t;

  // State is exactly the pair {main_valid, skid_valid}; SKID_ONLY cannot occur.
  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    SKID_ONLY = 2'b01,
    FULL1     = 2'b10,
    FULL2     = 2'b11
  } state_e;

  logic     r_main_vld;
  logic     r_skid_vld;
  payload_t r_main;
  payload_t r_skid;

  payload_t w_in;
  state_e   w_state;
  logic     w_accept;
  logic     w_drain;

  assign w_in.alu_result = mem_in.ALUResult;
  assign w_in.read_data  = mem_in.ReadData;
  assign w_in.pc_plus4   = mem_in.PCPlus4;
  assign w_in.rd         = mem_in.Rd;
  assign w_in.reg_write  = mem_in.RegWrite;
  assign w_in.result_src = mem_in.ResultSrc;

  assign w_state  = state_e'({r_main_vld, r_skid_vld});
  assign w_accept = mem_in.valid & ~r_skid_vld;
  assign w_drain  = r_main_vld & wb_out.ready;

  // Storage and handshake state: reset beats flush beats normal movement; skid is always the younger entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      // Payload is left as-is; only the valid flags matter for a kill.
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      case (w_state)
        EMPTY: begin
          if (w_accept) begin
            r_main     <= w_in;
            r_main_vld <= 1'b1;
          end
        end
        FULL1: begin
          if (w_accept && w_drain) begin
            r_main <= w_in;
          end else if (w_accept) begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
          end else if (w_drain) begin
            r_main_vld <= 1'b0;
          end
        end
        FULL2: begin
          if (w_drain) begin
            r_main     <= r_skid;
            r_skid_vld <= 1'b0;
          end
        end
        default: begin
          // Unreachable; recover to a clean state.
          r_skid_vld <= 1'b0;
        end
      endcase
    end
  end

  assign mem_in.ready     = ~r_skid_vld;
  assign wb_out.valid     = r_main_vld;
  assign wb_out.ALUResult = r_main.alu_result;
  assign wb_out.ReadData  = r_main.read_data;
  assign wb_out.PCPlus4   = r_main.pc_plus4;
  assign wb_out.Rd        = r_main.rd;
  assign wb_out.ResultSrc = r_main.result_src;
  // A bubble must never write the register file, whatever stale payload sits in main.
  assign wb_out.RegWrite  = r_main.reg_write & r_main_vld;

`ifdef MEMWB_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating stall/bubble counters, sampled on pre-edge state; flush does not touch them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_main_vld && !wb_out.ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!r_main_vld && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg; counter checks adapt to MEMWB_PERF_EN.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Built with CNT_W=4 so counter saturation is reachable quickly.
module tb_mem_wb_stage_reg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  int compared   = 0;
  int mismatched = 0;

  mem_wb_stage_reg_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) mem_if ();
  mem_wb_stage_reg_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) wb_if ();

  mem_wb_stage_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .mem_in     (mem_if.slave),
    .wb_out     (wb_if.master),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                       input logic [1:0] src);
    mem_if.valid     = v;
    mem_if.ALUResult = alu;
    mem_if.ReadData  = rdat;
    mem_if.PCPlus4   = pc4;
    mem_if.Rd        = rd;
    mem_if.RegWrite  = rw;
    mem_if.ResultSrc = src;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    wb_if.ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);

    // Reset state
    do_reset();
    chk("rst_out_valid", {31'b0, wb_if.valid}, 32'd0);
    chk("rst_in_ready", {31'b0, mem_if.ready}, 32'd1);
    chk("rst_alu", wb_if.ALUResult, 32'h0);
    chk("rst_rd", {27'b0, wb_if.Rd}, 32'd0);
    chk("rst_regwrite", {31'b0, wb_if.RegWrite}, 32'd0);
    chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
    chk("rst_bubble", {28'b0, bubble_cnt}, 32'd0);

    // Single entry, WB always ready
    wb_if.ready = 1'b1;
    drive(1'b1, 32'h1234, 32'hCAFE, 32'h104, 5'd5, 1'b1, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    chk("single_out_valid", {31'b0, wb_if.valid}, 32'd1);
    chk("single_alu", wb_if.ALUResult, 32'h1234);
    chk("single_rd", {27'b0, wb_if.Rd}, 32'd5);
    chk("single_regwrite", {31'b0, wb_if.RegWrite}, 32'd1);
    chk("single_readdata", wb_if.ReadData, 32'hCAFE);
    chk("single_src", {30'b0, wb_if.ResultSrc}, 32'd1);
    tick();
    chk("single_after_valid", {31'b0, wb_if.valid}, 32'd0);
    chk("single_after_regwrite", {31'b0, wb_if.RegWrite}, 32'd0);
    chk("single_after_hold_alu", wb_if.ALUResult, 32'h1234);

    // Back-pressure: A then B with WB stalled
    wb_if.ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00);
    tick();
    chk("bp_ready_after_a", {31'b0, mem_if.ready}, 32'd1);
    chk("bp_alu_a", wb_if.ALUResult, 32'hA);
    drive(1'b1, 32'hB, 32'h0, 32'h0, 5'd2, 1'b1, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    chk("bp_ready_after_b", {31'b0, mem_if.ready}, 32'd0);
    chk("bp_still_a", wb_if.ALUResult, 32'hA);
    tick();
    chk("bp_hold_a", wb_if.ALUResult, 32'hA);
    chk("bp_hold_ready", {31'b0, mem_if.ready}, 32'd0);
    wb_if.ready = 1'b1;
    tick();
    chk("bp_out_b_valid", {31'b0, wb_if.valid}, 32'd1);
    chk("bp_out_b_alu", wb_if.ALUResult, 32'hB);
    chk("bp_out_b_rd", {27'b0, wb_if.Rd}, 32'd2);
    chk("bp_ready_again", {31'b0, mem_if.ready}, 32'd1);
    tick();
    chk("bp_empty", {31'b0, wb_if.valid}, 32'd0);

    // Streaming 8 back-to-back entries
    do_reset();
    wb_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 32'h0, 32'h0, 5'(i), 1'b1, 2'b00);
      tick();
      chk($sformatf("stream_valid_%0d", i), {31'b0, wb_if.valid}, 32'd1);
      chk($sformatf("stream_alu_%0d", i), wb_if.ALUResult, i);
      chk($sformatf("stream_ready_%0d", i), {31'b0, mem_if.ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    tick();
    chk("stream_end_valid", {31'b0, wb_if.valid}, 32'd0);
`ifdef MEMWB_PERF_EN
    chk("stream_stall", {28'b0, stall_cnt}, 32'd0);
    chk("stream_bubble", {28'b0, bubble_cnt}, 32'd1);
`endif

    // Flush while FULL2 with an incoming entry
    wb_if.ready = 1'b0;
    drive(1'b1, 32'h11, 32'h0, 32'h0, 5'd3, 1'b1, 2'b00);
    tick();
    drive(1'b1, 32'h22, 32'h0, 32'h0, 5'd4, 1'b1, 2'b00);
    tick();
    chk("fl_full2_ready", {31'b0, mem_if.ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h33, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    chk("fl_out_valid", {31'b0, wb_if.valid}, 32'd0);
    chk("fl_regwrite", {31'b0, wb_if.RegWrite}, 32'd0);
    chk("fl_in_ready", {31'b0, mem_if.ready}, 32'd1);
    wb_if.ready = 1'b1;
    tick();
    chk("fl_quiet1", {31'b0, wb_if.valid}, 32'd0);
    tick();
    chk("fl_quiet2", {31'b0, wb_if.valid}, 32'd0);
    drive(1'b1, 32'h44, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    chk("fl_next_valid", {31'b0, wb_if.valid}, 32'd1);
    chk("fl_next_alu", wb_if.ALUResult, 32'h44);

    // Reset while stalled in FULL2
    wb_if.ready = 1'b0;
    drive(1'b1, 32'h55, 32'h66, 32'h77, 5'd9, 1'b1, 2'b10);
    tick();
    drive(1'b1, 32'h88, 32'h99, 32'hAA, 5'd10, 1'b1, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    chk("rs_full2_ready", {31'b0, mem_if.ready}, 32'd0);
    do_reset();
    chk("rs_out_valid", {31'b0, wb_if.valid}, 32'd0);
    chk("rs_alu", wb_if.ALUResult, 32'h0);
    chk("rs_readdata", wb_if.ReadData, 32'h0);
    chk("rs_pc4", wb_if.PCPlus4, 32'h0);
    chk("rs_rd", {27'b0, wb_if.Rd}, 32'd0);
    chk("rs_src", {30'b0, wb_if.ResultSrc}, 32'd0);
    chk("rs_regwrite", {31'b0, wb_if.RegWrite}, 32'd0);
    chk("rs_in_ready", {31'b0, mem_if.ready}, 32'd1);
    chk("rs_stall", {28'b0, stall_cnt}, 32'd0);
    chk("rs_bubble", {28'b0, bubble_cnt}, 32'd0);

    // Stall counter saturation: one held entry, WB stalled for 20 cycles
    wb_if.ready = 1'b0;
    drive(1'b1, 32'h5A, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) tick();
`ifdef MEMWB_PERF_EN
    chk("sat_stall", {28'b0, stall_cnt}, 32'd15);
    chk("sat_bubble", {28'b0, bubble_cnt}, 32'd1);
    tick();
    tick();
    chk("sat_stall_hold", {28'b0, stall_cnt}, 32'd15);
`else
    chk("off_stall", {28'b0, stall_cnt}, 32'd0);
    chk("off_bubble", {28'b0, bubble_cnt}, 32'd0);
`endif
    chk("sat_held_alu", wb_if.ALUResult, 32'h5A);
    chk("sat_held_valid", {31'b0, wb_if.valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
